exception_arbiter_unit: RTL and testbench

- Sits directly upstream of the CP0 cause register unit.
- Collects per-instruction exception requests from the MEM stage and the raw hardware interrupt lines, and picks the single highest-priority event.
- Drives the cause-update signals (exception_abort, exception_code, bd_p, irq, ip, r_p) that the cause unit latches.
- Sequences the pipeline flush and redirect to the exception vector with a small FSM.

---
 rtl/exception_arbiter_unit.sv | 139 +++++++++++++
 tb/tb_exception_arbiter_unit.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exception_arbiter_unit.sv
// Exception/interrupt arbiter feeding the CP0 cause unit: selects the highest-priority
// event of the MEM-stage instruction and sequences the flush and redirect to the vector.
//
// state  | meaning
// IDLE   | watching for an exception or unmasked interrupt on a valid MEM instruction
// COMMIT | single-cycle cause-update strobe, flush starts, counter loaded
// FLUSH  | flush held while the down-counter runs out; new events dropped
module exception_arbiter_unit #(
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  hw_int,
    input  logic [1:0]  sw_ip,
    input  logic        status_ie,
    input  logic        status_exl,
    input  logic [7:0]  status_im,
    input  logic        exc_valid,
    input  logic        exc_adel,
    input  logic        exc_ades,
    input  logic        exc_ri,
    input  logic        exc_ov,
    input  logic        exc_sys,
    input  logic        exc_bp,
    input  logic        exc_in_bd,
    input  logic [31:0] exc_pc,
    output logic        exception_abort,
    output logic        r_p,
    output logic [4:0]  exception_code,
    output logic        bd_p,
    output logic        irq,
    output logic [7:0]  ip,
    output logic [31:0] epc,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, COMMIT, FLUSH} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [5:0]  sync_q [SYNC_STAGES];
    logic [5:0]  hw_sync;
    logic        irq_c;
    logic        any_exc;
    logic        take;
    logic [4:0]  code_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= hw_int;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign hw_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            ip  <= '0;
            irq <= 1'b0;
        end else begin
            ip  <= {hw_sync, sw_ip};
            irq <= irq_c;
        end
    end

    assign irq_c   = status_ie & ~status_exl & (|(ip & status_im));
    assign any_exc = exc_adel | exc_ades | exc_ri | exc_ov | exc_sys | exc_bp;
    assign take    = (state == IDLE) & exc_valid & (irq_c | any_exc);

    // Interrupt outranks every synchronous exception on the same instruction.
    always_comb begin
        code_c = 5'd0;
        if (irq_c)         code_c = 5'd0;
        else if (exc_adel) code_c = 5'd4;
        else if (exc_ri)   code_c = 5'd10;
        else if (exc_ov)   code_c = 5'd12;
        else if (exc_sys)  code_c = 5'd8;
        else if (exc_bp)   code_c = 5'd9;
        else if (exc_ades) code_c = 5'd5;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (take) state_n = COMMIT;
            end
            COMMIT: begin
                cnt_n   = CNT_LOAD;
                state_n = FLUSH;
            end
            FLUSH: begin
                if (cnt == 4'd0) state_n = IDLE;
                else             cnt_n   = cnt - 4'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    // Cause fields hold until the next commit; they are not cleared on return to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            exception_code <= '0;
            bd_p           <= 1'b0;
            epc            <= '0;
        end else if (take) begin
            exception_code <= code_c;
            bd_p           <= exc_in_bd;
            epc            <= exc_in_bd ? exc_pc - 32'd4 : exc_pc;
        end
    end

    assign exception_abort = (state == COMMIT);
    assign r_p             = (state == COMMIT);
    assign flush           = (state != IDLE);
    assign busy            = (state != IDLE);
    assign redirect_pc     = EXC_VECTOR;

endmodule

// File: tb/tb_exception_arbiter_unit.sv
// Bench for exception_arbiter_unit: directed scenarios plus randomized traffic checked
// against an event-level model (delay-line interrupts, busy-cycle countdown, priority table).
module tb_exception_arbiter_unit;

    localparam int          FLUSH_CYCLES = 2;
    localparam logic [31:0] EXC_VECTOR   = 32'hBFC0_0380;
    localparam int          SYNC_STAGES  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  hw_int;
    logic [1:0]  sw_ip;
    logic        status_ie, status_exl;
    logic [7:0]  status_im;
    logic        exc_valid, exc_adel, exc_ades, exc_ri, exc_ov, exc_sys, exc_bp, exc_in_bd;
    logic [31:0] exc_pc;
    logic        exception_abort, r_p, bd_p, irq, flush, busy;
    logic [4:0]  exception_code;
    logic [7:0]  ip;
    logic [31:0] epc, redirect_pc;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [5:0]  m_hist[$];
    logic [7:0]  m_ip;
    logic        m_irq;
    int          m_flush_left;
    logic [4:0]  m_code;
    logic        m_bd;
    logic [31:0] m_epc;
    int          code_tab[7] = '{0, 4, 10, 12, 8, 9, 5};

    exception_arbiter_unit #(
        .FLUSH_CYCLES(FLUSH_CYCLES), .EXC_VECTOR(EXC_VECTOR), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .rst(rst), .hw_int(hw_int), .sw_ip(sw_ip),
        .status_ie(status_ie), .status_exl(status_exl), .status_im(status_im),
        .exc_valid(exc_valid), .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_ri(exc_ri),
        .exc_ov(exc_ov), .exc_sys(exc_sys), .exc_bp(exc_bp), .exc_in_bd(exc_in_bd),
        .exc_pc(exc_pc), .exception_abort(exception_abort), .r_p(r_p),
        .exception_code(exception_code), .bd_p(bd_p), .irq(irq), .ip(ip), .epc(epc),
        .flush(flush), .redirect_pc(redirect_pc), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic model_eval();
        logic       irq_c;
        logic [6:0] req;
        logic       found;
        if (rst) begin
            m_hist.delete();
            for (int i = 0; i < SYNC_STAGES; i++) m_hist.push_back(6'h0);
            m_ip = '0; m_irq = 1'b0; m_flush_left = 0;
            m_code = '0; m_bd = 1'b0; m_epc = '0;
        end else begin
            irq_c = status_ie & ~status_exl & (|(m_ip & status_im));
            req = {exc_ades, exc_bp, exc_sys, exc_ov, exc_ri, exc_adel, irq_c};
            if (m_flush_left > 0) begin
                m_flush_left--;
            end else if (exc_valid && req != 7'd0) begin
                found = 1'b0;
                for (int i = 0; i < 7; i++) begin
                    if (req[i] && !found) begin
                        m_code = 5'(code_tab[i]);
                        found = 1'b1;
                    end
                end
                m_bd = exc_in_bd;
                m_epc = exc_in_bd ? exc_pc - 32'd4 : exc_pc;
                m_flush_left = FLUSH_CYCLES + 1;
            end
            m_irq = irq_c;
            m_ip = {m_hist[0], sw_ip};
            void'(m_hist.pop_front());
            m_hist.push_back(hw_int);
        end
    endtask

    task automatic step();
        model_eval();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exc();
        exc_valid = 0; exc_adel = 0; exc_ades = 0; exc_ri = 0; exc_ov = 0;
        exc_sys = 0; exc_bp = 0; exc_in_bd = 0; exc_pc = '0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 20) begin step(); n++; end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL wait_idle: busy=%b required 0 within 20 cycles", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1; hw_int = 6'h3F; sw_ip = 0; status_ie = 0; status_exl = 0; status_im = 0;
        clear_exc();
        repeat (3) step();
        checks++;
        if ({exception_abort, r_p, exception_code, bd_p, irq, ip, epc, flush, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: abort=%b r_p=%b code=%0d bd=%b irq=%b ip=%h epc=%h flush=%b busy=%b required all 0",
                     exception_abort, r_p, exception_code, bd_p, irq, ip, epc, flush, busy);
        end
        checks++;
        if (redirect_pc !== 32'hBFC0_0380) begin
            failures++;
            $display("FAIL reset_redirect: got %h required bfc00380", redirect_pc);
        end
        rst = 0;
        repeat (SYNC_STAGES) step();
        checks++;
        if (ip[7:2] !== 6'h00) begin
            failures++;
            $display("FAIL sync_early: ip[7:2]=%h required 00 after %0d cycles", ip[7:2], SYNC_STAGES);
        end
        step();
        checks++;
        if (ip[7:2] !== 6'h3F) begin
            failures++;
            $display("FAIL sync_latency: ip[7:2]=%h required 3f after %0d cycles", ip[7:2], SYNC_STAGES + 1);
        end
        hw_int = 0;
        repeat (SYNC_STAGES + 2) step();
    endtask

    task automatic test_priority();
        int flush_n = 0;
        int abort_n = 0;
        exc_valid = 1; exc_ri = 1; exc_ov = 1; exc_bp = 1; exc_pc = 32'h8000_0100; exc_in_bd = 0;
        step();
        clear_exc();
        checks++;
        if (exception_abort !== 1'b1 || r_p !== 1'b1 || exception_code !== 5'd10 ||
            epc !== 32'h8000_0100 || bd_p !== 1'b0) begin
            failures++;
            $display("FAIL priority_commit: abort=%b r_p=%b code=%0d epc=%h bd=%b required 1 1 10 80000100 0",
                     exception_abort, r_p, exception_code, epc, bd_p);
        end
        for (int i = 0; i < 8; i++) begin
            if (flush === 1'b1) flush_n++;
            if (exception_abort === 1'b1) abort_n++;
            step();
        end
        checks++;
        if (flush_n !== FLUSH_CYCLES + 1 || abort_n !== 1) begin
            failures++;
            $display("FAIL priority_flush_len: flush cycles=%0d abort cycles=%0d required %0d and 1",
                     flush_n, abort_n, FLUSH_CYCLES + 1);
        end
        checks++;
        if (busy !== 1'b0 || exception_code !== 5'd10) begin
            failures++;
            $display("FAIL priority_hold: busy=%b code=%0d required 0 and 10", busy, exception_code);
        end
    endtask

    task automatic test_delay_slot();
        exc_valid = 1; exc_sys = 1; exc_in_bd = 1; exc_pc = 32'h0;
        step();
        clear_exc();
        checks++;
        if (exception_abort !== 1'b1 || exception_code !== 5'd8 || bd_p !== 1'b1 ||
            epc !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL delay_slot: abort=%b code=%0d bd=%b epc=%h required 1 8 1 fffffffc",
                     exception_abort, exception_code, bd_p, epc);
        end
        wait_idle();
    endtask

    task automatic test_int_gating();
        int aborts = 0;
        hw_int = 6'h01; status_im = 8'h04; status_ie = 1; status_exl = 0;
        repeat (SYNC_STAGES + 2) step();
        exc_valid = 1;
        step();
        clear_exc();
        checks++;
        if (exception_abort !== 1'b1 || exception_code !== 5'd0) begin
            failures++;
            $display("FAIL int_commit: abort=%b code=%0d required 1 0", exception_abort, exception_code);
        end
        wait_idle();
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL int_irq: irq=%b required 1", irq);
        end
        status_exl = 1; exc_valid = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (exception_abort !== 1'b0) aborts++;
        end
        checks++;
        if (irq !== 1'b0 || aborts !== 0) begin
            failures++;
            $display("FAIL int_exl_mask: irq=%b aborts=%0d required 0 0", irq, aborts);
        end
        exc_adel = 1;
        step();
        clear_exc();
        checks++;
        if (exception_abort !== 1'b1 || exception_code !== 5'd4) begin
            failures++;
            $display("FAIL int_exl_adel: abort=%b code=%0d required 1 4", exception_abort, exception_code);
        end
        wait_idle();
        hw_int = 0; status_ie = 0; status_exl = 0; status_im = 0;
        repeat (SYNC_STAGES + 2) step();
    endtask

    task automatic test_busy_drop();
        exc_valid = 1; exc_sys = 1; exc_pc = 32'h0000_1000;
        step();
        clear_exc();
        step();
        exc_valid = 1; exc_ov = 1;
        step();
        checks++;
        if (exception_abort !== 1'b0 || exception_code !== 5'd8 || busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_drop_mid: abort=%b code=%0d busy=%b required 0 8 1",
                     exception_abort, exception_code, busy);
        end
        step();
        checks++;
        if (exception_abort !== 1'b0 || exception_code !== 5'd8 || busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_drop_end: abort=%b code=%0d busy=%b required 0 8 0",
                     exception_abort, exception_code, busy);
        end
        clear_exc();
        step();
    endtask

    task automatic test_reset_mid_flush();
        exc_valid = 1; exc_ri = 1; exc_pc = 32'h0000_2000;
        step();
        clear_exc();
        step();
        rst = 1;
        step();
        rst = 0;
        checks++;
        if (flush !== 1'b0 || busy !== 1'b0 || exception_abort !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_flush: flush=%b busy=%b abort=%b required 0 0 0",
                     flush, busy, exception_abort);
        end
        exc_valid = 1; exc_bp = 1; exc_pc = 32'h0000_3000;
        step();
        clear_exc();
        checks++;
        if (exception_abort !== 1'b1 || exception_code !== 5'd9 || epc !== 32'h0000_3000) begin
            failures++;
            $display("FAIL reset_then_bp: abort=%b code=%0d epc=%h required 1 9 00003000",
                     exception_abort, exception_code, epc);
        end
        wait_idle();
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 400; c++) begin
            rst        = ($urandom_range(0, 79) == 0);
            hw_int     = 6'($urandom);
            sw_ip      = 2'($urandom);
            status_ie  = ($urandom_range(0, 3) != 0);
            status_exl = ($urandom_range(0, 3) == 0);
            status_im  = 8'($urandom);
            exc_valid  = ($urandom_range(0, 1) == 1);
            exc_adel   = ($urandom_range(0, 7) == 0);
            exc_ades   = ($urandom_range(0, 7) == 0);
            exc_ri     = ($urandom_range(0, 7) == 0);
            exc_ov     = ($urandom_range(0, 7) == 0);
            exc_sys    = ($urandom_range(0, 7) == 0);
            exc_bp     = ($urandom_range(0, 7) == 0);
            exc_in_bd  = ($urandom_range(0, 3) == 0);
            exc_pc     = ($urandom_range(0, 7) == 0) ? 32'h0 : {$urandom} & 32'hFFFF_FFFC;
            step();
            checks++;
            if (exception_abort !== (m_flush_left == FLUSH_CYCLES + 1) ||
                r_p !== (m_flush_left == FLUSH_CYCLES + 1) ||
                flush !== (m_flush_left > 0) || busy !== (m_flush_left > 0) ||
                exception_code !== m_code || bd_p !== m_bd || epc !== m_epc ||
                irq !== m_irq || ip !== m_ip || redirect_pc !== EXC_VECTOR) begin
                failures++;
                if (bad < 10)
                    $display("FAIL random_c%0d: abort=%b flush=%b busy=%b code=%0d bd=%b epc=%h irq=%b ip=%h required abort=%b flush=%b code=%0d bd=%b epc=%h irq=%b ip=%h",
                             c, exception_abort, flush, busy, exception_code, bd_p, epc, irq, ip,
                             m_flush_left == FLUSH_CYCLES + 1, m_flush_left > 0, m_code, m_bd,
                             m_epc, m_irq, m_ip);
                bad++;
            end
        end
        rst = 0;
        clear_exc();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_delay_slot();
        test_int_gating();
        test_busy_drop();
        test_reset_mid_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
